// File: rtl/bg_scaled_mapper.sv
// Nearest-neighbour scaled background mapper: beam position -> ROM address with
// horizontal wrap scrolling, plus a frame-timed fade-out/fade-in of the pixel colour.
module bg_scaled_mapper #(
   parameter int IMG_W       = 105,
   parameter int IMG_H       = 117,
   parameter int SCREEN_W    = 640,
   parameter int SCREEN_H    = 480,
   parameter int ADDR_W      = 15,
   parameter int IDX_W       = 4,
   parameter int FADE_FRAMES = 4
) (
   input  logic              vga_clk,
   input  logic              reset,
   input  logic [9:0]        DrawX,
   input  logic [9:0]        DrawY,
   input  logic              blank,
   input  logic [9:0]        scroll_x,
   input  logic              fade_start,
   output logic [ADDR_W-1:0] rom_address,
   input  logic [IDX_W-1:0]  rom_q,
   output logic [IDX_W-1:0]  pal_index,
   input  logic [3:0]        pal_red,
   input  logic [3:0]        pal_green,
   input  logic [3:0]        pal_blue,
   output logic [3:0]        red,
   output logic [3:0]        green,
   output logic [3:0]        blue,
   output logic              fade_black,
   output logic              fade_done
);

   // CW holds col + scroll, which stays below 2*IMG_W
   localparam int CW  = $clog2(IMG_W) + 1;
   localparam int XEW = $clog2(SCREEN_W + IMG_W) + 1;
   localparam int YEW = $clog2(SCREEN_H + IMG_H) + 1;
   localparam int FW  = $clog2(FADE_FRAMES + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_FADE_OUT, ST_BLACK, ST_FADE_IN} state_t;

   logic [CW-1:0]     col_r, col_s, scroll_q_r, scroll_s, sum_s, wrap_s;
   logic [XEW-1:0]    xerr_r, xerr_s, xerr_add_s;
   logic [YEW-1:0]    yerr_r, yerr_s, yerr_add_s;
   logic [ADDR_W-1:0] row_base_r, row_base_s, addr_s;
   logic [9:0]        last_y_r;
   logic              frame_start_s, blank_d1_r, blank_d2_r, done_s;
   state_t            state_r, state_s;
   logic [3:0]        level_r, level_s;
   logic [FW-1:0]     fcnt_r, fcnt_s;

   function automatic logic [3:0] scale_c(input logic [3:0] c, input logic [3:0] lvl);
      logic [7:0] prod;
      prod = {4'b0000, c} * ({4'b0000, lvl} + 8'd1);
      return 4'(prod >> 4);
   endfunction

   assign pal_index = rom_q;

   // Column/row error accumulators, scroll selection and address formation
   always_comb begin
      frame_start_s = (DrawX == 10'd0) && (DrawY == 10'd0);
      scroll_s      = scroll_q_r;
      if (frame_start_s) begin
         if (scroll_x < 10'(IMG_W)) scroll_s = CW'(scroll_x);
         else                       scroll_s = {CW{1'b0}};
      end else begin
         scroll_s = scroll_q_r;
      end

      xerr_add_s = xerr_r + XEW'(IMG_W);
      col_s      = col_r;
      xerr_s     = xerr_add_s;
      if (DrawX == 10'd0) begin
         col_s  = {CW{1'b0}};
         xerr_s = {XEW{1'b0}};
      end else if (xerr_add_s >= XEW'(SCREEN_W)) begin
         col_s  = col_r + CW'(1'b1);
         xerr_s = xerr_add_s - XEW'(SCREEN_W);
      end else begin
         col_s  = col_r;
         xerr_s = xerr_add_s;
      end

      yerr_add_s = yerr_r + YEW'(IMG_H);
      row_base_s = row_base_r;
      yerr_s     = yerr_r;
      if (DrawY == 10'd0) begin
         row_base_s = {ADDR_W{1'b0}};
         yerr_s     = {YEW{1'b0}};
      end else if ((DrawX == 10'd0) && (DrawY != last_y_r)) begin
         if (yerr_add_s >= YEW'(SCREEN_H)) begin
            row_base_s = row_base_r + ADDR_W'(IMG_W);
            yerr_s     = yerr_add_s - YEW'(SCREEN_H);
         end else begin
            row_base_s = row_base_r;
            yerr_s     = yerr_add_s;
         end
      end else begin
         row_base_s = row_base_r;
         yerr_s     = yerr_r;
      end

      sum_s = col_s + scroll_s;
      if (sum_s >= CW'(IMG_W)) wrap_s = sum_s - CW'(IMG_W);
      else                     wrap_s = sum_s;
      addr_s = row_base_s + ADDR_W'(wrap_s);
   end

   // Address pipeline state and blank alignment
   always_ff @(posedge vga_clk) begin
      if (reset) begin
         col_r       <= {CW{1'b0}};
         xerr_r      <= {XEW{1'b0}};
         row_base_r  <= {ADDR_W{1'b0}};
         yerr_r      <= {YEW{1'b0}};
         last_y_r    <= 10'd0;
         scroll_q_r  <= {CW{1'b0}};
         rom_address <= {ADDR_W{1'b0}};
         blank_d1_r  <= 1'b0;
         blank_d2_r  <= 1'b0;
      end else begin
         col_r       <= col_s;
         xerr_r      <= xerr_s;
         row_base_r  <= row_base_s;
         yerr_r      <= yerr_s;
         last_y_r    <= (DrawX == 10'd0) ? DrawY : last_y_r;
         scroll_q_r  <= scroll_s;
         rom_address <= addr_s;
         blank_d1_r  <= blank;
         blank_d2_r  <= blank_d1_r;
      end
   end

   // Fade FSM: next state, level and frame counter
   always_comb begin
      state_s = state_r;
      level_s = level_r;
      fcnt_s  = fcnt_r;
      done_s  = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (fade_start) begin
               state_s = ST_FADE_OUT;
               fcnt_s  = {FW{1'b0}};
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_FADE_OUT: begin
            if (frame_start_s) begin
               if (fcnt_r == FW'(FADE_FRAMES - 1)) begin
                  fcnt_s  = {FW{1'b0}};
                  level_s = level_r - 4'd1;
                  if (level_r == 4'd1) state_s = ST_BLACK;
                  else                 state_s = ST_FADE_OUT;
               end else begin
                  fcnt_s = fcnt_r + FW'(1'b1);
               end
            end else begin
               fcnt_s = fcnt_r;
            end
         end
         ST_BLACK: begin
            if (fade_start) begin
               state_s = ST_FADE_IN;
               fcnt_s  = {FW{1'b0}};
            end else begin
               state_s = ST_BLACK;
            end
         end
         ST_FADE_IN: begin
            if (frame_start_s) begin
               if (fcnt_r == FW'(FADE_FRAMES - 1)) begin
                  fcnt_s  = {FW{1'b0}};
                  level_s = level_r + 4'd1;
                  if (level_r == 4'd14) begin
                     state_s = ST_IDLE;
                     done_s  = 1'b1;
                  end else begin
                     state_s = ST_FADE_IN;
                  end
               end else begin
                  fcnt_s = fcnt_r + FW'(1'b1);
               end
            end else begin
               fcnt_s = fcnt_r;
            end
         end
         default: begin
            state_s = ST_IDLE;
            level_s = 4'hF;
            fcnt_s  = {FW{1'b0}};
         end
      endcase
   end

   // Fade state registers, status outputs and scaled colour output
   always_ff @(posedge vga_clk) begin
      if (reset) begin
         state_r    <= ST_IDLE;
         level_r    <= 4'hF;
         fcnt_r     <= {FW{1'b0}};
         fade_black <= 1'b0;
         fade_done  <= 1'b0;
         red        <= 4'd0;
         green      <= 4'd0;
         blue       <= 4'd0;
      end else begin
         state_r    <= state_s;
         level_r    <= level_s;
         fcnt_r     <= fcnt_s;
         fade_black <= (state_s == ST_BLACK);
         fade_done  <= done_s;
         red        <= blank_d2_r ? scale_c(pal_red,   level_r) : 4'd0;
         green      <= blank_d2_r ? scale_c(pal_green, level_r) : 4'd0;
         blue       <= blank_d2_r ? scale_c(pal_blue,  level_r) : 4'd0;
      end
   end

endmodule

// File: tb/tb_bg_scaled_mapper.sv
// Directed bench for bg_scaled_mapper: address vectors, reduced-frame sweeps,
// pipeline latency, blanking and the fade state machine.
module tb_bg_scaled_mapper;

   logic        vga_clk = 1'b0;
   logic        reset, blank, fade_start;
   logic [9:0]  DrawX, DrawY, scroll_x;
   logic [14:0] rom_address;
   logic [3:0]  rom_q, pal_index, pal_red, pal_green, pal_blue;
   logic [3:0]  red, green, blue;
   logic        fade_black, fade_done;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;

   typedef struct {
      int x;
      int y;
      int s;
      int exp;
   } vec_t;
   vec_t vecs[13];

   always #5 vga_clk = ~vga_clk;

   bg_scaled_mapper dut (
      .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY),
      .blank(blank), .scroll_x(scroll_x), .fade_start(fade_start),
      .rom_address(rom_address), .rom_q(rom_q), .pal_index(pal_index),
      .pal_red(pal_red), .pal_green(pal_green), .pal_blue(pal_blue),
      .red(red), .green(green), .blue(blue),
      .fade_black(fade_black), .fade_done(fade_done)
   );

   // synchronous image ROM model
   always @(posedge vga_clk) rom_q <= rom_address[3:0] ^ rom_address[7:4];

   function automatic int model_addr(int x, int y, int s);
      int ss;
      ss = (s >= 105) ? 0 : s;
      return (y * 117 / 480) * 105 + ((x * 105 / 640) + ss) % 105;
   endfunction

   function automatic int scale(int c, int lvl);
      return (c * (lvl + 1)) / 16;
   endfunction

   task automatic step();
      @(posedge vga_clk);
      #1;
      if (fade_done === 1'b1) done_cnt++;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic run_to(int x, int y, int s);
      int lastx;
      DrawX = 10'd0; DrawY = 10'd0; scroll_x = 10'(s);
      step();
      scroll_x = 10'd57;
      for (int ry = 0; ry <= y; ry++) begin
         lastx = (ry == y) ? x : 0;
         for (int cx = 0; cx <= lastx; cx++) begin
            if (!(ry == 0 && cx == 0)) begin
               DrawX = 10'(cx); DrawY = 10'(ry);
               step();
            end
         end
      end
   endtask

   task automatic sweep(int s);
      int ncols;
      for (int y = 0; y < 480; y++) begin
         ncols = (y < 3 || y == 239 || y >= 478) ? 640 : 4;
         for (int x = 0; x < ncols; x++) begin
            DrawX = 10'(x); DrawY = 10'(y);
            scroll_x = (x == 0 && y == 0) ? 10'(s) : 10'd57;
            step();
            check($sformatf("sweep_s%0d_%0d_%0d", s, x, y), 32'(rom_address), model_addr(x, y, s));
         end
      end
   endtask

   task automatic frames(int n);
      repeat (n) begin
         DrawX = 10'd0; DrawY = 10'd0; step();
         DrawX = 10'd0; DrawY = 10'd1; step();
      end
   endtask

   task automatic pulse_fade();
      DrawX = 10'd5; DrawY = 10'd1; fade_start = 1'b1;
      step();
      fade_start = 1'b0;
   endtask

   task automatic check_color(input string name, int lvl);
      DrawX = 10'd5; DrawY = 10'd1; blank = 1'b1;
      step(); step(); step();
      check({name, "_r"}, 32'(red),   scale(15, lvl));
      check({name, "_g"}, 32'(green), scale(10, lvl));
      check({name, "_b"}, 32'(blue),  scale(5, lvl));
   endtask

   initial begin
      vecs[0]  = '{0,   0,   0,   0};
      vecs[1]  = '{639, 0,   0,   104};
      vecs[2]  = '{0,   479, 0,   12180};
      vecs[3]  = '{639, 479, 0,   12284};
      vecs[4]  = '{0,   0,   10,  10};
      vecs[5]  = '{639, 0,   10,  9};
      vecs[6]  = '{639, 479, 10,  12189};
      vecs[7]  = '{0,   0,   200, 0};
      vecs[8]  = '{639, 479, 200, 12284};
      vecs[9]  = '{639, 0,   104, 103};
      vecs[10] = '{639, 0,   105, 104};
      vecs[11] = '{320, 240, 0,   6142};
      vecs[12] = '{7,   5,   0,   106};

      reset = 1'b1; blank = 1'b1; fade_start = 1'b0;
      DrawX = 10'd0; DrawY = 10'd0; scroll_x = 10'd0;
      pal_red = 4'hF; pal_green = 4'hA; pal_blue = 4'h5;
      step(); step();
      check("reset_red", 32'(red), 0);
      check("reset_green", 32'(green), 0);
      check("reset_blue", 32'(blue), 0);
      check("reset_addr", 32'(rom_address), 0);
      check("reset_black", 32'(fade_black), 0);
      check("reset_done", 32'(fade_done), 0);

      // first visible pixel reaches the colour outputs three cycles later
      reset = 1'b0; blank = 1'b0; DrawX = 10'd5; DrawY = 10'd1;
      step(); step(); step();
      blank = 1'b1;
      step(); check("lat_t1", 32'(red), 0);
      step(); check("lat_t2", 32'(red), 0);
      step(); check("lat_t3_r", 32'(red), 15);
      check("lat_t3_g", 32'(green), 10);
      check("lat_t3_b", 32'(blue), 5);
      blank = 1'b0;
      step(); check("blank_t1", 32'(red), 15);
      step(); check("blank_t2", 32'(red), 15);
      step(); check("blank_t3", 32'(red), 0);
      blank = 1'b1;

      for (int i = 0; i < 13; i++) begin
         run_to(vecs[i].x, vecs[i].y, vecs[i].s);
         check($sformatf("vec%0d_addr", i), 32'(rom_address), vecs[i].exp);
         step();
         check($sformatf("vec%0d_pidx", i), 32'(pal_index), (vecs[i].exp & 15) ^ ((vecs[i].exp >> 4) & 15));
      end

      sweep(0);
      sweep(10);
      sweep(200);

      // fade-out, with a fade_start mid-fade that must be ignored
      check_color("idle", 15);
      pulse_fade();
      frames(10);
      pulse_fade();
      frames(22);
      check_color("lvl7", 7);
      frames(27);
      check("black_at59", 32'(fade_black), 0);
      check_color("lvl1", 1);
      frames(1);
      check("black_at60", 32'(fade_black), 1);
      check_color("lvl0", 0);
      frames(5);
      check("black_hold", 32'(fade_black), 1);

      // fade-in back to full level
      done_cnt = 0;
      pulse_fade();
      check("black_cleared", 32'(fade_black), 0);
      frames(59);
      check("done_before", done_cnt, 0);
      check_color("lvl14", 14);
      frames(1);
      check("done_once", done_cnt, 1);
      check_color("lvl15", 15);
      frames(8);
      check("done_no_repeat", done_cnt, 1);

      // reset part-way through a fade-out
      pulse_fade();
      frames(40);
      check_color("lvl5", 5);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("rst_black", 32'(fade_black), 0);
      check("rst_red", 32'(red), 0);
      check_color("rst_lvl15", 15);

      // fade_start on a frame-start cycle: that frame start is not counted
      DrawX = 10'd0; DrawY = 10'd0; fade_start = 1'b1;
      step();
      fade_start = 1'b0; DrawY = 10'd1;
      step();
      frames(3);
      check_color("coinc_lvl15", 15);
      frames(1);
      check_color("coinc_lvl14", 14);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bg_scaled_mapper.md
# bg_scaled_mapper

Parametrised successor to the per-level background mappers. It converts the VGA beam position into a source-image ROM address by nearest-neighbour scaling, computed with per-pixel step accumulators instead of multiply/divide. It adds horizontal scrolling with wrap-around and a frame-timed fade-out/fade-in state machine for level transitions. The ROM and palette stay external, so one instance serves any level image; the block sits between the VGA controller and the colour outputs.

## Interface
- IMG_W, 105: source image width in pixels.
- IMG_H, 117: source image height in pixels.
- SCREEN_W, 640: visible horizontal pixels.
- SCREEN_H, 480: visible vertical lines.
- ADDR_W, 15: ROM address width; must satisfy 2^ADDR_W ≥ IMG_W*IMG_H.
- IDX_W, 4: palette index width.
- FADE_FRAMES, 4: frames per fade level step, ≥1.
- vga_clk  in  1  pixel clock; the only clock.
- reset  in  1  synchronous, active-high.
- DrawX  in  10  beam column; increments by 1 per vga_clk within a line.
- DrawY  in  10  beam line.
- blank  in  1  high = visible pixel.
- scroll_x  in  10  horizontal source offset in image pixels.
- fade_start  in  1  single-cycle request to start a fade.
- rom_address  out  ADDR_W  registered address to external synchronous ROM.
- rom_q  in  IDX_W  ROM data, one cycle after rom_address.
- pal_index  out  IDX_W  rom_q forwarded to the external combinational palette.
- pal_red, pal_green, pal_blue  in  4 each  palette colour for pal_index.
- red, green, blue  out  4 each  registered pixel colour.
- fade_black  out  1  high while in state BLACK.
- fade_done  out  1  one-cycle pulse when the fade-in completes.

## Operation
- Source column: col(DrawX) = floor(DrawX*IMG_W/SCREEN_W). Source row: row(DrawY) = floor(DrawY*IMG_H/SCREEN_H).
  - Both use an error accumulator: add IMG_W (or IMG_H) per step and subtract SCREEN_W (or SCREEN_H) on overflow.
  - The column resets when DrawX==0. The row steps once per line when DrawX==0 and DrawY changes, and resets when DrawY==0.
  - No multipliers or dividers in the address path. The row base advances by IMG_W per row step.
- Address = row_base + ((col + scroll_q) mod IMG_W). The wrap is a single conditional subtract.
- scroll_q is latched at frame start (cycle with DrawX==0 && DrawY==0). A scroll_x value ≥ IMG_W latches as 0.
- Fade FSM states: IDLE (level 15), FADE_OUT, BLACK (level 0), FADE_IN.
  - IDLE: fade_start → FADE_OUT.
  - FADE_OUT: level decrements every FADE_FRAMES frame starts. On reaching 0 → BLACK.
  - BLACK: fade_start → FADE_IN.
  - FADE_IN: level increments every FADE_FRAMES frame starts. On reaching 15 → IDLE, with fade_done pulsed that cycle.
  - fade_start in FADE_OUT or FADE_IN is ignored.
  - The frame counter clears on every state change.
- Colour scaling: out = (pal_c * (level+1)) >> 4 per channel. Level 15 is the identity; level 0 is black.
- When delayed blank is low, red/green/blue = 0.

## Timing
- Reset values: red/green/blue = 0, rom_address = 0, fade_black = 0, fade_done = 0, state IDLE, level 15, scroll_q = 0, accumulators 0.
- Pixel sampled at cycle t:
  - rom_address valid at t+1.
  - rom_q / pal_index at t+2.
  - red/green/blue registered at t+3.
- blank is delayed 3 cycles to stay aligned with its pixel.
- Level changes take effect on the frame-start cycle. A pixel already in the pipeline uses the level current when it reaches the output register.
- fade_start coinciding with a frame start: the transition happens that cycle, and that frame start is not counted.
- Reset mid-fade returns to IDLE, level 15 on the next cycle.

## Test plan
- Reset held 2 cycles with blank=1 → red/green/blue=0, rom_address=0. First output after release appears 3 cycles after the first pixel.
- Full 640×480 sweep, scroll 0, defaults → rom_address for (0,0)=0, (639,0)=104, (0,479)=12180, (639,479)=12284. Every address matches the floor formula.
- scroll_x=10 latched at frame start → (0,0) gives address 10; (639,0) gives address 9 (wrap).
- scroll_x=200 → latched as 0, addresses identical to the unscrolled sweep.
- Palette constant 0xF, fade_start pulse, FADE_FRAMES=4:
  - After 32 frame starts, level=7 and output=7.
  - After 60 frame starts, fade_black=1 and output=0.
  - Second fade_start → after 60 frame starts, output 0xF with fade_done pulsed once.
- fade_start during FADE_OUT is ignored. blank=0 forces 0 output with a 3-cycle lag. Reset at level 5 → level 15 next cycle.
